// File: rtl/progmem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface progmem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // master: byte source plus memory; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/progmem_loader.sv
// Loads a length-prefixed little-endian byte stream into 32-bit instruction memory and holds the core
// until the image is in; defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte before release.
module progmem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  progmem_loader_if.slave bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       part_q, part_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              rx_ready;
  logic              accept;
  logic              last_word;
  logic [15:0]       n_full;

  always_comb begin
    rx_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) || (state_q == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state_q == S_CHECK) rx_ready = 1'b1;
`endif
  end

  assign accept    = bus.rx_valid && rx_ready;
  assign n_full    = {bus.rx_data, n_q[7:0]};
  // The previous word has always committed by the next lane-3 byte, so the count doubles as the index.
  assign last_word = (16'(words_loaded_q) + 16'd1) == n_q;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    lane_d         = lane_q;
    part_d         = part_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = mem_we_q ? (words_loaded_q + {{ADDR_W{1'b0}}, 1'b1}) : words_loaded_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d         = accept ? (csum_q ^ bus.rx_data) : csum_q;
`endif

    case (state_q)
      S_CNT_LO: begin
        if (accept) begin
          n_d[7:0] = bus.rx_data;
          state_d  = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (accept) begin
          n_d = n_full;
          if (n_full > 16'(DEPTH)) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          lane_d = lane_q + 2'd1;
          part_d = {bus.rx_data, part_q[23:8]};
          if (lane_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = words_loaded_q[ADDR_W-1:0];
            mem_wdata_d = {bus.rx_data, part_q};
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DRAIN;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.rx_data != csum_q) state_d = S_ERR;
          else if (mem_we_q)         state_d = S_DRAIN;
          else                       state_d = S_DONE;
        end
      end
`endif

      // Release only once the last write has committed, so the first fetch sees the whole image.
      S_DRAIN: begin
        if (!mem_we_q) state_d = S_DONE;
      end

      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_CNT_LO;
      n_q            <= '0;
      lane_q         <= '0;
      part_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      lane_q         <= lane_d;
      part_q         <= part_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      words_loaded_q <= words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign cpu_hold      = (state_q != S_DONE);
  assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Bench for progmem_loader: builds byte streams from word images and checks the writes and flags against them.
module tb_progmem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_hold;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  progmem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  progmem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and release observations, taken mid-cycle
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                wr_wl[$];
  int                wr_cyc[$];
  int                done_rise[$];
  bit                prev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_wl.push_back(int'(words_loaded));
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1 && !prev_done) done_rise.push_back(cyc);
    prev_done <= (done === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] img_words[$];
  logic [7:0]  stream[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    acc = 1'b0;
    idle(gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = (bus.rx_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (acc) last_acc_cyc = cyc;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_rx_ready"},  bus.rx_ready,  1);
    check({t, "_cpu_hold"},  cpu_hold,      1);
    check({t, "_mem_we"},    bus.mem_we,    0);
    check({t, "_mem_addr"},  bus.mem_addr,  0);
    check({t, "_mem_wdata"}, bus.mem_wdata, 0);
    check({t, "_done"},      done,          0);
    check({t, "_error"},     error,         0);
    check({t, "_words"},     words_loaded,  0);
  endtask

  // Reference: stream = N lo, N hi, words LSB first, [XOR of all bytes]; word i lands at address i.
  task automatic run_image(input string tag, input int n, input int gap, input bit bad_csum, input bit do_rst);
    int  base;
    int  refused;
    int  exp_w;
    int  nwr;
    bit  good;
    bit  acc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs;
`endif
    if (do_rst) do_reset();
    base = wr_addr.size();
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) stream.push_back(8'(img_words[i] >> (8 * k)));
`ifdef LOADER_CHECKSUM_EN
      cs = 8'h00;
      foreach (stream[j]) cs ^= stream[j];
      stream.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`endif
    end else begin
      for (int k = 0; k < 4; k++) stream.push_back(8'($urandom));
    end

    refused = 0;
    foreach (stream[j]) begin
      send_byte(stream[j], (gap < 0) ? int'($urandom_range(0, 3)) : gap, acc);
      if (!acc) refused++;
      if (j == 1 && n > DEPTH) check({tag, "_err_latency"}, error, 1);
    end
    for (int i = 0; i < 60 && !(done === 1'b1 || error === 1'b1); i++) idle(1);
    idle(3);

    good  = (n <= DEPTH) && !bad_csum;
    exp_w = (n <= DEPTH) ? n : 0;
    nwr   = wr_addr.size() - base;
    check({tag, "_refused"},  refused, (n <= DEPTH) ? 0 : 4);
    check({tag, "_done"},     done,     good);
    check({tag, "_error"},    error,    !good);
    check({tag, "_cpu_hold"}, cpu_hold, !good);
    check({tag, "_rx_ready"}, bus.rx_ready, 0);
    check({tag, "_words"},    words_loaded, exp_w);
    check({tag, "_nwrites"},  nwr, exp_w);
    for (int i = 0; i < exp_w && i < nwr; i++) begin
      check({tag, "_addr"},   wr_addr[base + i], i);
      check({tag, "_data"},   wr_data[base + i], img_words[i]);
      check({tag, "_wl_at_we"}, wr_wl[base + i], i);
    end

    send_byte(8'h5A, 0, acc);
    idle(2);
    check({tag, "_trail_acc"},   acc, 0);
    check({tag, "_trail_nwr"},   wr_addr.size() - base, exp_w);
  endtask

  initial begin
    int  nrise;
    int  n;
    bit  acc;

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    rst = 1'b0;
    check_reset_vals("reset");

    // Two-word image from the reference program
    img_words = '{32'h0000_0033, 32'h0010_0093};
    nrise = done_rise.size();
    run_image("img1", 2, 0, 1'b0, 1'b1);
    check("img1_rise_cnt", done_rise.size(), nrise + 1);
    if (done_rise.size() > 0 && wr_cyc.size() > 0)
      check("img1_done_latency", done_rise[$], wr_cyc[$] + 2);

    // Empty image
    nrise = done_rise.size();
    run_image("n0", 0, 0, 1'b0, 1'b1);
    check("n0_rise_cnt", done_rise.size(), nrise + 1);
    if (done_rise.size() > 0) check("n0_done_latency", done_rise[$], last_acc_cyc);

    // Oversized counts
    run_image("n257", 257, 0, 1'b0, 1'b1);
    run_image("n4096", 4096, 1, 1'b0, 1'b1);

    // Same image with long idle gaps
    img_words = '{32'h0000_0033, 32'h0010_0093};
    run_image("gap5", 2, 5, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    run_image("badcs", 2, 0, 1'b1, 1'b1);
`endif

    // Reset in the middle of a word, then a clean reload
    do_reset();
    send_byte(8'h02, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h33, 0, acc);
    send_byte(8'h00, 0, acc);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_vals("midrst");
    run_image("afterrst", 2, -1, 1'b0, 1'b0);

    // Random images with random gaps
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 12));
      img_words.delete();
      for (int i = 0; i < n; i++) img_words.push_back($urandom);
      run_image("rnd", n, -1, 1'b0, 1'b1);
    end

    // Full-depth image
    img_words.delete();
    for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom);
    run_image("full", DEPTH, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/progmem_loader.md
# progmem_loader

Byte-stream program loader that fills the SOC's 32-bit instruction memory before the core runs. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles words, and writes them into the instruction memory. It holds the CPU in reset until the image is complete. It sits between a byte source (UART receiver or test host) and the instruction memory write port, and drives the core's hold/reset input.

## Interface
- `DEPTH`, 256: instruction memory depth in 32-bit words.
- `ADDR_W`, 8: word address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset; the only reset.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte.
- `mem_we`  out  1  instruction memory write strobe, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  word address (word index, not byte address).
- `mem_wdata`  out  32  assembled word.
- `cpu_hold`  out  1  high = keep core in reset.
- `done`  out  1  image loaded and accepted.
- `error`  out  1  load failed.
- `words_loaded`  out  ADDR_W+1  count of words written so far.

## Operation
- A byte is accepted on any rising edge with `rx_valid && rx_ready`. No other byte is consumed.
- Stream format:
  - N lo, then N hi: 16-bit word count N.
  - N×4 payload bytes, each word least-significant byte first.
  - One checksum byte, only when the macro is enabled.
- States: CNT_LO → CNT_HI → DATA → [CHECK] → DONE; any state may go to ERR.
- CNT_LO: accept byte into N[7:0].
- CNT_HI: accept byte into N[15:8].
  - N > DEPTH → ERR.
  - N = 0 → CHECK (macro on) or DONE.
  - Otherwise → DATA.
- DATA: 2-bit byte lane counter; bytes fill lanes 0..3 of a shift/holding register.
  - On lane-3 accept, `mem_we` pulses next cycle with `mem_addr` = word index and `mem_wdata` = {b3,b2,b1,b0}.
  - Word index then increments; `words_loaded` increments on the same edge as the write commits.
  - After word N-1 is accepted, next state is CHECK (macro on) or DONE.
- DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0. Sticky until RESET.
- ERR: `error`=1, `cpu_hold`=1, `rx_ready`=0, no further writes. Sticky until RESET.
- `rx_ready`=1 in CNT_LO, CNT_HI, DATA and CHECK, including the `mem_we` cycle. The write datapath is registered separately, so no stall is needed.
- `mem_addr` never exceeds DEPTH-1. Wrap-around is impossible because N ≤ DEPTH is enforced.

## Timing
- Reset values (cycle after RESET sampled high):
  - state = CNT_LO.
  - `rx_ready`=1, `cpu_hold`=1.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `done`=0, `error`=0, `words_loaded`=0.
  - Partial word and checksum accumulator cleared.
- RESET mid-operation discards any partial word. Already-written memory words are not cleared.
- Write latency: the lane-3 byte is accepted at edge E; `mem_we` is high for cycle E..E+1; the write commits at edge E+1.
- Release: `done`=1 and `cpu_hold`=0 go high one cycle after the final write commits (visible after edge E+2). This guarantees the core's first fetch sees word 0..N-1 valid.
- N=0, macro off: `done` visible one cycle after the N-hi accept.
- ERR is entered one cycle after the offending byte is accepted.
- Idle cycles (`rx_valid`=0) of any length between bytes change nothing.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The loader keeps a running XOR of every accepted byte, count bytes included.
  - CHECK accepts one byte: equal to the accumulator → DONE; else → ERR.
  - DONE/`cpu_hold` release happens one cycle after the checksum byte is accepted, or after the final write commits, whichever is later.
- Not defined:
  - No accumulator and no CHECK state.
  - DONE follows the final write as in Timing.
  - Any trailing byte sees `rx_ready`=0 and is not consumed.

## Test plan
- Bytes 02 00 33 00 00 00 93 00 10 00 (+B2 with macro) → `mem_we` at addr 0 data 0x00000033, then addr 1 data 0x00100093; then `done`=1, `cpu_hold`=0, `words_loaded`=2, `error`=0.
- Bytes 00 00 (+00 with macro) → no `mem_we`; `done`=1; `words_loaded`=0.
- Bytes 01 01 (N=257, DEPTH=256) → `error`=1, `rx_ready`=0, `cpu_hold`=1; no `mem_we` even if further bytes are offered.
- Same image as the first test, with `rx_valid` low for 5 cycles between every byte → identical writes and final flags; no byte is duplicated or dropped.
- Macro on, first-test image with checksum 0xB3 → both words written, then `error`=1, `done`=0, `cpu_hold`=1.
- RESET pulsed after N and 2 payload bytes → all outputs at reset values next cycle; a fresh full first-test stream then loads correctly, with word 0 = 0x00000033.
